// File: rtl/sample_pair_packer.sv
// Raster-to-pair packer feeding the column DWT 9/7 stage.
// Turns a one-sample-per-beat sof/eol framed stream into {odd, even} pairs,
// mirrors the missing sample of odd-length lines (x[N] = x[N-2]), tracks the
// first line length of each frame and raises a sticky framing error.
// The pair output is fully registered.
module sample_pair_packer #(
    parameter int DataWidth       = 16,
    parameter int MaximumSideSize = 512,
    localparam int LenW           = $clog2(MaximumSideSize + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [DataWidth-1:0]   s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic [LenW-1:0]        line_len_o,
    output logic                   len_err_o
);

    // One extra counter bit so the saturation value MaximumSideSize+1 always fits.
    localparam int CntW = LenW + 1;
    localparam logic [CntW-1:0] CntSat = CntW'(MaximumSideSize + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaximumSideSize);

    typedef enum logic {ST_EVEN, ST_ODD} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DataWidth-1:0]   r_even;
    logic                   r_sof_held;
    logic [DataWidth-1:0]   r_prev_odd;
    logic                   r_prev_vld;
    logic [CntW-1:0]        r_cnt;
    logic                   r_first;
    logic [LenW-1:0]        r_line_len;
    logic                   r_err;
    logic                   r_m_valid;
    logic                   r_m_sof;
    logic                   r_m_eol;
    logic [2*DataWidth-1:0] r_m_data;

    logic                   w_accept;
    logic                   w_as_even;
    logic [CntW-1:0]        w_cnt_base;
    logic [CntW-1:0]        w_cnt_inc;
    logic                   w_first_eff;
    logic                   w_err_set;
    logic                   w_load;
    logic [2*DataWidth-1:0] w_pair;
    logic                   w_pair_sof;
    logic                   w_pair_eol;

    assign s_ready_o  = !r_m_valid | m_ready_i;
    assign w_accept   = s_valid_i & s_ready_o;
    // A sof always restarts pairing; a sample held in ODD is abandoned.
    assign w_as_even  = (r_state == ST_EVEN) | s_sof_i;

    // The sof sample counts as the first sample of a fresh line.
    assign w_cnt_base = s_sof_i ? '0 : r_cnt;
    assign w_cnt_inc  = (w_cnt_base >= CntSat) ? CntSat : w_cnt_base + CntW'(1);

    // An eol on the sof beat itself is still the first eol of the frame.
    assign w_first_eff = s_sof_i | r_first;

    assign w_err_set = w_accept &
                       ((s_sof_i & (r_state == ST_ODD)) |
                        (w_cnt_inc > CntMax) |
                        (s_eol_i & !w_first_eff & (w_cnt_inc != {1'b0, r_line_len})));

    // Next state and the pair to load into the output register
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pair      = r_m_data;
        w_pair_sof  = 1'b0;
        w_pair_eol  = 1'b0;
        if (w_accept) begin
            if (w_as_even) begin
                if (s_eol_i) begin
                    // Odd-length line: mirror x[N-2]; a 1-sample line pairs with itself.
                    w_load      = 1'b1;
                    w_pair      = {(r_prev_vld & !s_sof_i) ? r_prev_odd : s_data_i, s_data_i};
                    w_pair_sof  = s_sof_i;
                    w_pair_eol  = 1'b1;
                    w_state_nxt = ST_EVEN;
                end else begin
                    w_state_nxt = ST_ODD;
                end
            end else begin
                w_load      = 1'b1;
                w_pair      = {s_data_i, r_even};
                w_pair_sof  = r_sof_held;
                w_pair_eol  = s_eol_i;
                w_state_nxt = ST_EVEN;
            end
        end
    end

    // State, held samples, line counting and error tracking
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_EVEN;
            r_even     <= '0;
            r_sof_held <= 1'b0;
            r_prev_odd <= '0;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_line_len <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= s_eol_i ? '0 : w_cnt_inc;
                if (w_as_even && !s_eol_i) begin
                    r_even     <= s_data_i;
                    r_sof_held <= s_sof_i;
                end
                if (!w_as_even) begin
                    r_prev_odd <= s_data_i;
                end
                // The mirror source is only valid within the current line.
                if (s_eol_i || s_sof_i) begin
                    r_prev_vld <= 1'b0;
                end else if (!w_as_even) begin
                    r_prev_vld <= 1'b1;
                end
                if (s_eol_i && w_first_eff) begin
                    r_line_len <= w_cnt_inc[LenW-1:0];
                end
                if (s_eol_i) begin
                    r_first <= 1'b0;
                end else if (s_sof_i) begin
                    r_first <= 1'b1;
                end
                // sof clears the sticky error, but an error raised on that beat wins.
                if (s_sof_i) begin
                    r_err <= w_err_set;
                end else begin
                    r_err <= r_err | w_err_set;
                end
            end
        end
    end

    // Output pair register: load on a completed pair, drop when consumed
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_m_valid <= 1'b0;
            r_m_sof   <= 1'b0;
            r_m_eol   <= 1'b0;
            r_m_data  <= '0;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_sof   <= w_pair_sof;
            r_m_eol   <= w_pair_eol;
            r_m_data  <= w_pair;
        end else if (m_ready_i) begin
            r_m_valid <= 1'b0;
            r_m_sof   <= 1'b0;
            r_m_eol   <= 1'b0;
        end
    end

    assign m_valid_o  = r_m_valid;
    assign m_sof_o    = r_m_sof;
    assign m_eol_o    = r_m_eol;
    assign m_data_o   = r_m_data;
    assign line_len_o = r_line_len;
    assign len_err_o  = r_err;

endmodule

// File: tb/tb_sample_pair_packer.sv
// Directed vector table plus hand sequences and a random-stall model check
// for sample_pair_packer (small MaximumSideSize to reach the overlength case).
module tb_sample_pair_packer;

    localparam int DW   = 16;
    localparam int MAXS = 8;
    localparam int LW   = $clog2(MAXS + 1);

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            s_ready_o;
    logic            s_valid_i;
    logic            s_sof_i;
    logic            s_eol_i;
    logic [DW-1:0]   s_data_i;
    logic            m_ready_i;
    logic            m_valid_o;
    logic            m_sof_o;
    logic            m_eol_o;
    logic [2*DW-1:0] m_data_o;
    logic [LW-1:0]   line_len_o;
    logic            len_err_o;

    int n_chk = 0;
    int n_err = 0;

    sample_pair_packer #(.DataWidth(DW), .MaximumSideSize(MAXS)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .s_ready_o(s_ready_o), .s_valid_i(s_valid_i),
        .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_data_i(s_data_i), .m_ready_i(m_ready_i),
        .m_valid_o(m_valid_o), .m_sof_o(m_sof_o), .m_eol_o(m_eol_o), .m_data_o(m_data_o),
        .line_len_o(line_len_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, sof, eol;
        logic [15:0] d;
        logic        ev, esof, eeol;
        logic [31:0] ed;
        logic [3:0]  elen;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic sof, input logic eol, input logic [15:0] d,
                       input logic ev, input logic esof, input logic eeol, input logic [31:0] ed,
                       input logic [3:0] elen, input logic eerr);
        vec_t t;
        t.v = v; t.sof = sof; t.eol = eol; t.d = d;
        t.ev = ev; t.esof = esof; t.eeol = eeol; t.ed = ed; t.elen = elen; t.eerr = eerr;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sof, input logic eol,
                         input logic [15:0] d, input logic rdy);
        s_valid_i = v; s_sof_i = sof; s_eol_i = eol; s_data_i = d; m_ready_i = rdy;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Random-phase model state
    int          lens[6] = '{4, 5, 1, 3, 2, 6};
    logic [33:0] expq[$];

    initial begin
        logic [39:0]  act, exp;
        logic [15:0]  held, prevo, nxt;
        logic         hsof, pv, ptaken;
        logic [33:0]  pout, e;
        int           li, pos, ln;

        // 4x2 frame, samples 1..8
        add(1,1,0,16'h0001, 0,0,0,32'h0,         4'd0,0);
        add(1,0,0,16'h0002, 1,1,0,32'h0002_0001, 4'd0,0);
        add(1,0,0,16'h0003, 0,0,0,32'h0,         4'd0,0);
        add(1,0,1,16'h0004, 1,0,1,32'h0004_0003, 4'd4,0);
        add(1,0,0,16'h0005, 0,0,0,32'h0,         4'd4,0);
        add(1,0,0,16'h0006, 1,0,0,32'h0006_0005, 4'd4,0);
        add(1,0,0,16'h0007, 0,0,0,32'h0,         4'd4,0);
        add(1,0,1,16'h0008, 1,0,1,32'h0008_0007, 4'd4,0);
        // odd 5-sample line in a new frame
        add(1,1,0,16'h000A, 0,0,0,32'h0,         4'd4,0);
        add(1,0,0,16'h000B, 1,1,0,32'h000B_000A, 4'd4,0);
        add(1,0,0,16'h000C, 0,0,0,32'h0,         4'd4,0);
        add(1,0,0,16'h000D, 1,0,0,32'h000D_000C, 4'd4,0);
        add(1,0,1,16'h000E, 1,0,1,32'h000D_000E, 4'd5,0);
        // single-sample line
        add(1,1,1,16'h7FFF, 1,1,1,32'h7FFF_7FFF, 4'd1,0);
        // lines of 4 then 3 -> length error
        add(1,1,0,16'h0021, 0,0,0,32'h0,         4'd1,0);
        add(1,0,0,16'h0022, 1,1,0,32'h0022_0021, 4'd1,0);
        add(1,0,0,16'h0023, 0,0,0,32'h0,         4'd1,0);
        add(1,0,1,16'h0024, 1,0,1,32'h0024_0023, 4'd4,0);
        add(1,0,0,16'h0031, 0,0,0,32'h0,         4'd4,0);
        add(1,0,0,16'h0032, 1,0,0,32'h0032_0031, 4'd4,0);
        add(1,0,1,16'h0033, 1,0,1,32'h0032_0033, 4'd4,1);
        // dangling sample then sof: held 0x41 dropped, error stays set
        add(1,0,0,16'h0041, 0,0,0,32'h0,         4'd4,1);
        add(1,1,0,16'h0051, 0,0,0,32'h0,         4'd4,1);
        add(1,0,0,16'h0052, 1,1,0,32'h0052_0051, 4'd4,1);
        add(1,0,0,16'h0053, 0,0,0,32'h0,         4'd4,1);
        add(1,0,1,16'h0054, 1,0,1,32'h0054_0053, 4'd4,1);
        // clean frame clears the error
        add(1,1,0,16'h0061, 0,0,0,32'h0,         4'd4,0);
        add(1,0,0,16'h0062, 1,1,0,32'h0062_0061, 4'd4,0);
        add(1,0,1,16'h0063, 1,0,1,32'h0062_0063, 4'd3,0);
        // 9-sample line exceeds MAXS=8
        for (int k = 0; k < 9; k++) begin
            logic [15:0] dk, dp;
            dk = 16'h0070 + 16'(k);
            dp = 16'h0070 + 16'(k) - 16'd1;
            if (k == 8)
                add(1,0,1,dk, 1,0,1,{16'h0077, dk}, 4'd9,1);
            else if (k % 2 == 1)
                add(1,0,0,dk, 1,(k==1),0,{dk, dp}, 4'd3,0);
            else
                add(1,(k==0),0,dk, 0,0,0,32'h0, 4'd3,0);
        end
        add(0,0,0,16'h0000, 0,0,0,32'h0, 4'd9,1);

        // Reset state
        rst_ni = 1'b0;
        drive(0,0,0,16'h0,1);
        step; step;
        chk("reset_state", {m_valid_o, m_sof_o, m_eol_o, m_data_o, line_len_o, len_err_o}, '0);
        rst_ni = 1'b1;
        #1;
        chk("reset_ready", s_ready_o, 1);

        // Table
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].sof, tbl[i].eol, tbl[i].d, 1'b1);
            step;
            act = {m_valid_o, tbl[i].ev ? {m_sof_o, m_eol_o, m_data_o} : 34'h0, line_len_o, len_err_o};
            exp = {tbl[i].ev, tbl[i].ev ? {tbl[i].esof, tbl[i].eeol, tbl[i].ed} : 34'h0,
                   tbl[i].elen, tbl[i].eerr};
            chk($sformatf("vec%0d", i), act, exp);
        end

        // Backpressure: pair held stable, input blocked for 3 cycles
        drive(1,1,0,16'h00A0,1); step;
        drive(1,0,0,16'h00A1,1); step;
        chk("stall_pair", {m_valid_o, m_sof_o, m_data_o}, {1'b1, 1'b1, 32'h00A1_00A0});
        drive(1,0,0,16'h00A2,0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall_ready%0d", c), s_ready_o, 0);
            step;
            chk($sformatf("stall_hold%0d", c), {m_valid_o, m_sof_o, m_data_o},
                {1'b1, 1'b1, 32'h00A1_00A0});
        end
        drive(1,0,0,16'h00A2,1);
        #1;
        chk("stall_release_ready", s_ready_o, 1);
        step;
        chk("stall_consumed", m_valid_o, 0);
        drive(1,0,1,16'h00A3,1); step;
        chk("stall_next_pair", {m_valid_o, m_sof_o, m_eol_o, m_data_o, line_len_o},
            {1'b1, 1'b0, 1'b1, 32'h00A3_00A2, 4'd4});

        // Reset while ODD with error set
        drive(1,0,0,16'h00C0,1); step;
        drive(1,1,0,16'h00D0,1); step;
        chk("pre_reset_err", len_err_o, 1);
        rst_ni = 1'b0;
        drive(0,0,0,16'h0,1); step;
        chk("reset_odd_clear", {m_valid_o, len_err_o, line_len_o}, '0);
        rst_ni = 1'b1;
        drive(1,0,0,16'h00E0,1); step;
        drive(1,0,0,16'h00E1,1); step;
        chk("after_reset_even", {m_valid_o, m_sof_o, m_data_o}, {1'b1, 1'b0, 32'h00E1_00E0});
        drive(0,0,0,16'h0,1); step;

        // Reset while a pair is pending
        drive(1,0,0,16'h00F0,0); step;
        drive(1,0,0,16'h00F1,0); step;
        chk("pending_pair", {m_valid_o, m_data_o}, {1'b1, 32'h00F1_00F0});
        rst_ni = 1'b0;
        drive(0,0,0,16'h0,0); step;
        rst_ni = 1'b1;
        chk("reset_drops_pair", m_valid_o, 0);
        drive(0,0,0,16'h0,1); step;
        chk("no_stale_pair", m_valid_o, 0);

        // Random stalls against a reference model
        li = 0; pos = 0; nxt = 16'h0100; held = '0; prevo = '0; hsof = 0;
        pv = 0; ptaken = 0; pout = '0;
        for (int cyc = 0; cyc < 1100; cyc++) begin
            ln = lens[li % 6];
            drive((cyc < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0,
                  (pos == 0) && (li % 3 == 0), (pos == ln - 1), nxt,
                  (cyc < 1000) ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(negedge clk);
            chk("rnd_ready", s_ready_o, !m_valid_o | m_ready_i);
            if (pv && !ptaken)
                chk("rnd_stable", {m_valid_o, m_sof_o, m_eol_o, m_data_o}, {1'b1, pout});
            if (m_valid_o && m_ready_i) begin
                if (expq.size() == 0) begin
                    chk("rnd_unexpected", {m_sof_o, m_eol_o, m_data_o}, 64'hDEAD);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_pair", {m_sof_o, m_eol_o, m_data_o}, e);
                end
            end
            pv = m_valid_o; ptaken = m_ready_i; pout = {m_sof_o, m_eol_o, m_data_o};
            if (s_valid_i && s_ready_o) begin
                if (pos % 2 == 0) begin
                    if (s_eol_i)
                        expq.push_back({s_sof_i, 1'b1, (pos == 0) ? s_data_i : prevo, s_data_i});
                    else begin
                        held = s_data_i; hsof = s_sof_i;
                    end
                end else begin
                    expq.push_back({hsof, s_eol_i, s_data_i, held});
                    prevo = s_data_i;
                end
                nxt = nxt + 16'd1;
                if (s_eol_i) begin
                    pos = 0; li++;
                end else begin
                    pos++;
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sample_pair_packer.md
Name: sample_pair_packer

Overview:
- Upstream neighbour of the column DWT 9/7 stage.
- Converts a one-sample-per-beat raster stream (sof/eol framed) into the {odd, even} pair stream the column DWT consumes.
- Applies whole-sample symmetric extension to odd-length lines, tracks line length per frame, and flags framing errors.
- Output is registered, so the pair bus to the DWT carries no combinational path.

Parameters:
- DataWidth, 16, bits per sample.
- MaximumSideSize, 512, maximum samples per line; LenW = $clog2(MaximumSideSize+1).

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- s_ready_o  output  1  input ready.
- s_valid_i  input  1  input valid.
- s_sof_i  input  1  first sample of frame.
- s_eol_i  input  1  last sample of line.
- s_data_i  input  DataWidth  sample.
- m_ready_i  input  1  downstream ready.
- m_valid_o  output  1  pair valid.
- m_sof_o  output  1  first pair of frame.
- m_eol_o  output  1  last pair of line.
- m_data_o  output  2*DataWidth  {odd, even}: odd in [2*DataWidth-1:DataWidth], even in [DataWidth-1:0].
- line_len_o  output  LenW  sample count of the first line of the current frame.
- len_err_o  output  1  sticky framing/length error.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - m_valid_o, m_sof_o, m_eol_o, len_err_o = 0; m_data_o, line_len_o = 0.
  - State = EVEN; sample counter = 0; first-line flag = 1.
  - Reset mid-operation discards any held sample and any pending output.
- Handshake:
  - Input accept = s_valid_i & s_ready_o.
  - s_ready_o = !m_valid_o | m_ready_i; it does not depend on s_valid_i.
  - m_valid_o holds, with m_data_o/m_sof_o/m_eol_o stable, until m_ready_i.
- State EVEN, accept without eol:
  - even_q <= s_data_i; sof_q <= s_sof_i; go to ODD. No output.
- State ODD, accept:
  - Output register <= {s_data_i, even_q}; m_sof_o <= sof_q; m_eol_o <= s_eol_i.
  - prev_odd_q <= s_data_i.
  - Next state EVEN.
- State EVEN, accept with eol (odd-length line):
  - Output {prev_odd_q, s_data_i}, i.e. x[N] = x[N-2].
  - If the line has length 1, output {s_data_i, s_data_i}.
  - m_eol_o=1; m_sof_o=s_sof_i; state stays EVEN.
- Latency: the pair is visible one cycle after the accepting edge of its last sample; throughput is one pair per two input beats.
- Sample counter:
  - Increments per accepted sample; saturates at MaximumSideSize+1.
  - Cleared after eol or accepted sof (sof sample counts as 1).
  - prev_odd_q is invalidated at line start.
- Line length and errors:
  - At the first eol after sof, line_len_o <= count including the eol sample; the first-line flag clears.
  - Subsequent eol with count != line_len_o sets len_err_o.
  - Count > MaximumSideSize sets len_err_o.
- sof arriving in state ODD (dangling sample from a truncated line):
  - Held even_q is dropped and len_err_o is set.
  - The sof sample is processed as EVEN.
- Accepted sof:
  - Clears len_err_o unless the same beat also sets it; set wins over clear.
  - Sets the first-line flag.
- Simultaneous sof and eol on one sample (1-sample line): emit {x0, x0} with m_sof_o=1, m_eol_o=1; line_len_o=1.
- No arithmetic on data; widths are preserved bit-exactly.

Test Plan:
- Frame 4x2, samples 1..8, sof on 1, eol on 4 and 8, m_ready_i=1 -> pairs {2,1} sof, {4,3} eol, {6,5}, {8,7} eol; line_len_o=4, len_err_o=0.
- Odd line 5 samples 10,11,12,13,14 (eol on 14) -> {11,10}, {13,12}, {13,14} eol; line_len_o=5.
- Single-sample line 0x7FFF with sof+eol -> one pair {0x7FFF,0x7FFF}, m_sof_o=1, m_eol_o=1.
- Backpressure with m_ready_i low 3 cycles during a pair -> m_data_o stable, s_ready_o=0 while blocked, no sample lost or duplicated; compare against a reference model over 1000 random stall cycles.
- Second line shorter (4 then 3 samples), then sof mid-pair (state ODD) -> len_err_o rises after the short eol; held sample is dropped; next frame's sof clears len_err_o only on clean frames.
- Reset asserted while m_valid_o=1 and state ODD -> next cycle m_valid_o=0, len_err_o=0, and the next accepted sample is treated as even.
